ws2812_strip_driver: RTL and testbench

- Parametrised successor to the fixed four-strip LED driver.
- Streams a frame of GRB pixel words from a framebuffer dual-port RAM (registered read, 1-cycle latency) to NUM_STRIPS WS2812-style single-wire outputs in parallel.
- Bit timing, strip count, pixel width and frame length are configurable; adds per-strip enable, runtime pixel count, retrigger queuing and a done pulse.
- Sits between the framebuffer RAM and the strip output pins, triggered by the frame-complete strobe from the FTDI receive path.

---
 rtl/ws2812_strip_driver_if.sv | 27 ++
 rtl/ws2812_strip_driver.sv | 166 ++++++++++++++++
 tb/tb_ws2812_strip_driver.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_strip_driver_if.sv
// Frame control, framebuffer read port and strip output lines of ws2812_strip_driver.
// The driver takes the master side; the framebuffer/trigger environment takes the slave side.
interface ws2812_strip_driver_if #(
    parameter int NUM_STRIPS = 4,
    parameter int BPP        = 24,
    parameter int ADDR_WIDTH = 8
);
    logic                                frame_start;
    logic [ADDR_WIDTH-1:0]               num_pixels;
    logic [NUM_STRIPS-1:0]               strip_en;
    logic [NUM_STRIPS-1:0][BPP-1:0]      strip_rdata;
    logic [ADDR_WIDTH-1:0]               strip_raddr;
    logic                                strip_re;
    logic [NUM_STRIPS-1:0]               strip_out;
    logic                                busy;
    logic                                frame_done;

    modport master (
        input  frame_start, num_pixels, strip_en, strip_rdata,
        output strip_raddr, strip_re, strip_out, busy, frame_done
    );

    modport slave (
        output frame_start, num_pixels, strip_en, strip_rdata,
        input  strip_raddr, strip_re, strip_out, busy, frame_done
    );
endinterface

// File: rtl/ws2812_strip_driver.sv
// Streams GRB pixel words from a registered-read framebuffer to NUM_STRIPS WS2812 lines.
// One shared bit timer drives all strips; each strip owns its shift and next-pixel registers.
module ws2812_lane #(
    parameter int BPP = 24
) (
    input  logic           sys_clk,
    input  logic           rst,
    input  logic           ld_first,
    input  logic           ld_next,
    input  logic           shift,
    input  logic           cap,
    input  logic           send,
    input  logic           en,
    input  logic           lt_t0,
    input  logic           lt_t1,
    input  logic [BPP-1:0] rdata,
    output logic           out
);
    logic [BPP-1:0] shreg, nxt;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            nxt   <= '0;
        end else begin
            if (cap) nxt <= rdata;
            if (ld_first)     shreg <= rdata;
            else if (ld_next) shreg <= nxt;
            else if (shift)   shreg <= {shreg[BPP-2:0], 1'b0};
        end
    end

    assign out = send & en & (shreg[BPP-1] ? lt_t1 : lt_t0);
endmodule

module ws2812_strip_driver #(
    parameter int NUM_STRIPS = 4,
    parameter int BPP        = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int T0H_CYC    = 20,
    parameter int T1H_CYC    = 40,
    parameter int TBIT_CYC   = 63,
    parameter int TRST_CYC   = 14000
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    ws2812_strip_driver_if.master bus
);
    localparam int CW = $clog2(TBIT_CYC + 1);
    localparam int BW = $clog2(BPP + 1);
    localparam int LW = $clog2(TRST_CYC + 1);
    localparam logic [CW-1:0] TBIT_M1 = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] T0H_L   = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_L   = CW'(T1H_CYC);
    localparam logic [BW-1:0] BPP_M1  = BW'(BPP - 1);
    localparam logic [LW-1:0] TRST_M1 = LW'(TRST_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SEND, S_LATCH} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         bit_q;
    logic [LW-1:0]         lcnt_q;
    logic [ADDR_WIDTH-1:0] pix_q, npix_q, raddr_q, raddr_d;
    logic [NUM_STRIPS-1:0] en_q, out_w;
    logic                  pend_q, rd_vld_q;
    logic                  re_d, busy_d, done_d;
    logic                  in_send, bit_end, pix_end, last_pix, lat_end, restart, start, prefetch;

    assign in_send  = (state_q == S_SEND);
    assign bit_end  = in_send && (cnt_q == TBIT_M1);
    assign pix_end  = bit_end && (bit_q == BPP_M1);
    assign last_pix = (pix_q == npix_q);
    assign lat_end  = (state_q == S_LATCH) && (lcnt_q == TRST_M1);
    assign restart  = lat_end && (pend_q || bus.frame_start);
    assign start    = ((state_q == S_IDLE) && bus.frame_start) || restart;
    // Next pixel is requested at its predecessor's first cycle, leaving a whole pixel of slack.
    assign prefetch = in_send && (cnt_q == '0) && (bit_q == '0) && !last_pix;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        re_d    = 1'b0;
        raddr_d = raddr_q;
        done_d  = 1'b0;
        busy_d  = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (bus.frame_start) state_d = S_FETCH;
            S_FETCH: begin
                re_d    = 1'b1;
                raddr_d = '0;
                state_d = S_LOAD;
            end
            S_LOAD:  state_d = S_SEND;
            S_SEND: begin
                if (prefetch) begin
                    re_d    = 1'b1;
                    raddr_d = pix_q + 1'b1;
                end
                if (pix_end && last_pix) state_d = S_LATCH;
            end
            S_LATCH: if (lat_end) begin
                done_d  = 1'b1;
                state_d = restart ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            bit_q    <= '0;
            lcnt_q   <= '0;
            pix_q    <= '0;
            npix_q   <= '0;
            raddr_q  <= '0;
            en_q     <= '0;
            pend_q   <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            raddr_q  <= raddr_d;
            rd_vld_q <= prefetch;
            cnt_q    <= (in_send && !bit_end) ? cnt_q + 1'b1 : '0;
            lcnt_q   <= ((state_q == S_LATCH) && !lat_end) ? lcnt_q + 1'b1 : '0;
            if (!in_send)    bit_q <= '0;
            else if (bit_end) bit_q <= pix_end ? '0 : bit_q + 1'b1;
            if (state_q == S_FETCH)       pix_q <= '0;
            else if (pix_end && !last_pix) pix_q <= pix_q + 1'b1;
            if (start) begin
                npix_q <= bus.num_pixels;
                en_q   <= bus.strip_en;
            end
            // Any number of triggers while active collapse into one queued frame.
            if (restart)                                      pend_q <= 1'b0;
            else if ((state_q != S_IDLE) && bus.frame_start) pend_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_STRIPS; k++) begin : g_lane
        ws2812_lane #(.BPP(BPP)) u_lane (
            .sys_clk  (sys_clk),
            .rst      (rst),
            .ld_first (state_q == S_LOAD),
            .ld_next  (pix_end && !last_pix),
            .shift    (bit_end),
            .cap      (rd_vld_q),
            .send     (in_send),
            .en       (en_q[k]),
            .lt_t0    (cnt_q < T0H_L),
            .lt_t1    (cnt_q < T1H_L),
            .rdata    (bus.strip_rdata[k]),
            .out      (out_w[k])
        );
    end

    assign bus.strip_re    = re_d;
    assign bus.strip_raddr = raddr_d;
    assign bus.busy        = busy_d;
    assign bus.frame_done  = done_d;
    assign bus.strip_out   = out_w;
endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Random-stimulus bench: a frame-level reference model queues expected reads, words and
// done times; a monitor decodes the strip waveforms and pops/compares as the DUT produces them.
module tb_ws2812_strip_driver;
    localparam int NS = 4, BPP = 24, AW = 3;
    localparam int T0H = 3, T1H = 7, TBIT = 10, TRST = 20;
    localparam int PIX_CYC = BPP * TBIT;
    localparam int NWORDS = 1 << AW;

    typedef struct { int cyc; int addr; } rd_t;

    logic clk = 0;
    logic rst = 0;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   done_seen = 0;

    ws2812_strip_driver_if #(.NUM_STRIPS(NS), .BPP(BPP), .ADDR_WIDTH(AW)) bus();

    ws2812_strip_driver #(
        .NUM_STRIPS(NS), .BPP(BPP), .ADDR_WIDTH(AW),
        .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT), .TRST_CYC(TRST)
    ) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    logic [NS-1:0][BPP-1:0] mem [NWORDS];
    always @(posedge clk) if (bus.strip_re) bus.strip_rdata <= mem[bus.strip_raddr];

    // reference model and scoreboard queues
    bit              m_act, m_pend;
    int              m_done, m_first, m_busy_from;
    rd_t             exp_rd[$];
    int              exp_done[$];
    logic [BPP-1:0]  exp_w[NS][$];
    rd_t             rd_pop;

    // per-strip waveform decoder
    int              hi_len[NS];
    int              last_rise[NS];
    int              nbits[NS];
    bit              prv[NS];
    bit              have_rise[NS];
    logic [BPP-1:0]  word[NS];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flush();
        exp_rd.delete();
        exp_done.delete();
        for (int k = 0; k < NS; k++) begin
            exp_w[k].delete();
            nbits[k] = 0; hi_len[k] = 0; prv[k] = 0; have_rise[k] = 0;
        end
        m_act = 0;
        m_pend = 0;
    endtask

    task automatic start_frame(input int t, input bit from_idle);
        int np;
        np = int'(bus.num_pixels);
        m_act = 1;
        m_pend = 0;
        m_busy_from = from_idle ? t + 1 : t;
        m_first = t + 3;
        m_done = t + 2 + (np + 1) * PIX_CYC + TRST;
        exp_done.push_back(m_done);
        for (int a = 0; a <= np; a++) begin
            rd_t r;
            r.addr = a;
            r.cyc  = (a == 0) ? t + 1 : t + 3 + (a - 1) * PIX_CYC;
            exp_rd.push_back(r);
        end
        for (int k = 0; k < NS; k++)
            if (bus.strip_en[k])
                for (int p = 0; p <= np; p++) exp_w[k].push_back(mem[p][k]);
    endtask

    task automatic model_step();
        if (m_act && cyc == m_done) begin
            if (m_pend || bus.frame_start) start_frame(cyc, 0);
            else m_act = 0;
        end else if (!m_act && bus.frame_start) start_frame(cyc, 1);
        else if (m_act && bus.frame_start) m_pend = 1;
    endtask

    task automatic decode(input int k);
        bit o, b;
        o = bus.strip_out[k];
        if (o) begin
            if (!prv[k]) begin
                if (have_rise[k]) chk("bit_period", cyc - last_rise[k], TBIT);
                else              chk("first_rise", cyc, m_first);
                have_rise[k] = 1;
                last_rise[k] = cyc;
                hi_len[k] = 0;
            end
            hi_len[k]++;
        end else if (prv[k]) begin
            b = hi_len[k] > (T0H + T1H) / 2;
            chk("pulse_len", hi_len[k], b ? T1H : T0H);
            word[k] = {word[k][BPP-2:0], b};
            nbits[k]++;
            if (nbits[k] == BPP) begin
                nbits[k] = 0;
                chk("word_expected", exp_w[k].size() != 0, 1);
                if (exp_w[k].size() != 0) chk("strip_word", word[k], exp_w[k].pop_front());
            end
        end
        prv[k] = o;
    endtask

    initial begin
        flush();
        forever begin
            @(negedge clk);
            if (rst) flush();
            else begin
                chk("busy", bus.busy, (m_act && cyc >= m_busy_from));
                if (bus.strip_re) begin
                    chk("re_expected", exp_rd.size() != 0, 1);
                    if (exp_rd.size() != 0) begin
                        rd_pop = exp_rd.pop_front();
                        chk("re_cycle", cyc, rd_pop.cyc);
                        chk("re_addr", bus.strip_raddr, rd_pop.addr);
                    end
                end
                for (int k = 0; k < NS; k++) decode(k);
                if (bus.frame_done) begin
                    done_seen++;
                    chk("done_expected", exp_done.size() != 0, 1);
                    if (exp_done.size() != 0) chk("done_cycle", cyc, exp_done.pop_front());
                    chk("re_missing", exp_rd.size(), 0);
                    for (int k = 0; k < NS; k++) begin
                        chk("word_missing", exp_w[k].size(), 0);
                        chk("partial_bits", nbits[k], 0);
                        have_rise[k] = 0;
                    end
                end
                model_step();
            end
        end
    end

    // stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int t);
        bus.frame_start = 1;
        t = cyc;
        step();
        bus.frame_start = 0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((bus.busy || m_act) && n < limit) begin
            step();
            n++;
        end
        chk("idle_in_time", n < limit, 1);
    endtask

    task automatic rand_mem();
        for (int a = 0; a < NWORDS; a++)
            for (int k = 0; k < NS; k++) mem[a][k] = BPP'($urandom);
    endtask

    initial begin
        int t, t2, d0;
        bus.frame_start = 0;
        bus.num_pixels  = '0;
        bus.strip_en    = '0;
        rand_mem();
        #1 rst = 1;
        repeat (3) step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_re", bus.strip_re, 0);
        chk("rst_out", bus.strip_out, 0);
        chk("rst_done", bus.frame_done, 0);
        chk("rst_raddr", bus.strip_raddr, 0);
        rst = 0;
        step();

        // single pixel
        mem[0][0] = 24'hFF0000;
        mem[0][1] = 24'h000001;
        bus.num_pixels = 0;
        bus.strip_en = 4'hF;
        pulse_start(t);
        wait_idle(400);

        // full frame
        rand_mem();
        bus.num_pixels = 3'd7;
        pulse_start(t);
        wait_idle(2500);

        // enable mask
        for (int a = 0; a < NWORDS; a++) mem[a] = {NS{24'hFFFFFF}};
        bus.strip_en = 4'b0101;
        pulse_start(t);
        wait_idle(2500);

        // retrigger during SEND: three triggers give one extra frame
        rand_mem();
        bus.num_pixels = 3'd2;
        bus.strip_en = 4'hF;
        d0 = done_seen;
        pulse_start(t);
        repeat (50) step();
        repeat (3) begin
            pulse_start(t2);
            repeat (4) step();
        end
        wait_idle(3000);
        chk("retrig_done_count", done_seen - d0, 2);

        // trigger landing exactly on the last latch cycle
        bus.num_pixels = 0;
        bus.strip_en = 4'($urandom);
        d0 = done_seen;
        pulse_start(t);
        while (cyc < t + 2 + PIX_CYC + TRST) step();
        pulse_start(t2);
        wait_idle(1000);
        chk("edge_retrig_done_count", done_seen - d0, 2);

        // asynchronous reset in the middle of pixel 3
        rand_mem();
        mem[3] = {NS{24'hFFFFFF}};
        bus.num_pixels = 3'd7;
        bus.strip_en = 4'hF;
        pulse_start(t);
        while (cyc < t + 3 + 3 * PIX_CYC + 45) step();
        chk("pre_rst_busy", bus.busy, 1);
        chk("pre_rst_out", bus.strip_out, 4'hF);
        #2 rst = 1;
        #1;
        chk("async_rst_out", bus.strip_out, 0);
        chk("async_rst_re", bus.strip_re, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_raddr", bus.strip_raddr, 0);
        step();
        step();
        rst = 0;
        step();
        rand_mem();
        pulse_start(t);
        wait_idle(2500);

        // inputs changed mid-frame only affect the following frame
        rand_mem();
        bus.num_pixels = 3'd7;
        bus.strip_en = 4'hF;
        pulse_start(t);
        repeat (300) step();
        bus.num_pixels = 3'd1;
        bus.strip_en = 4'b1010;
        wait_idle(2500);
        rand_mem();
        pulse_start(t);
        wait_idle(800);

        // random frames
        repeat (5) begin
            rand_mem();
            bus.num_pixels = 3'($urandom_range(0, 7));
            bus.strip_en = 4'($urandom);
            pulse_start(t);
            wait_idle(2500);
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (3) step();
        chk("final_rd_queue", exp_rd.size(), 0);
        chk("final_done_queue", exp_done.size(), 0);
        for (int k = 0; k < NS; k++) chk("final_word_queue", exp_w[k].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
